multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Main control FSM for the multicycle RV32I core. It sequences one instruction at a time through fetch, decode, execute, memory and writeback over a single shared ALU and a single memory port. Each cycle it drives the datapath mux selects, register and memory write enables, and the 3-bit `ALUOp` consumed by the ALU decoder. Memory accesses use a request/ready handshake, so fetch and data accesses tolerate variable-latency memory.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `opcode`  in  7  `Instr[6:0]` from the instruction register.
- `branch_taken`  in  1  branch condition from the datapath, valid in BRANCH.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `mem_req`  out  1  memory access request.
- `MemWrite`  out  1  access is a store.
- `AdrSrc`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `IRWrite`  out  1  load IR and OldPC.
- `PCWrite`  out  1  load PC from Result.
- `RegWrite`  out  1  register file write.
- `ResultSrc`  out  2  Result select: 00 = ALUOut, 01 = Data, 10 = ALU result direct.
- `ALUSrcA`  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1, 11 = zero.
- `ALUSrcB`  out  2  ALU B select: 00 = rs2, 01 = imm, 10 = constant 4.
- `ALUOp`  out  3  000 = add, 001 = sub, 010 = decode from funct3/funct7.
- `ImmSrc`  out  3  immediate format: I = 000, S = 001, B = 010, J = 011, U = 100.
- `illegal_instr`  out  1  sticky illegal-opcode flag.

## Operation
Outputs are Moore, per state. Any field not listed below is 0.

State outputs:
- **FETCH**: `mem_req`=1, `AdrSrc`=0, `ALUSrcA`=00, `ALUSrcB`=10, `ALUOp`=000, `ResultSrc`=10. `IRWrite` and `PCWrite` equal `mem_ready`.
- **DECODE**: `ALUSrcA`=01, `ALUSrcB`=01, `ALUOp`=000. This computes the branch/jump target.
- **MEMADR**: `ALUSrcA`=10, `ALUSrcB`=01, `ALUOp`=000.
- **MEMREAD**: `mem_req`=1, `AdrSrc`=1.
- **MEMWRITE**: `mem_req`=1, `AdrSrc`=1, `MemWrite`=1.
- **MEMWB**: `ResultSrc`=01, `RegWrite`=1.
- **EXECR**: `ALUSrcA`=10, `ALUSrcB`=00, `ALUOp`=010.
- **EXECI**: `ALUSrcA`=10, `ALUSrcB`=01, `ALUOp`=010.
- **ALUWB**: `ResultSrc`=00, `RegWrite`=1.
- **BRANCH**: `ALUSrcA`=10, `ALUSrcB`=00, `ALUOp`=001, `ResultSrc`=00, `PCWrite`=`branch_taken`.
- **JAL**: `ALUSrcA`=01, `ALUSrcB`=10, `ALUOp`=000, `ResultSrc`=00, `PCWrite`=1.
- **JALR**: `ALUSrcA`=10, `ALUSrcB`=01, `ALUOp`=000, `ResultSrc`=10, `PCWrite`=1.
- **JALRLINK**: `ALUSrcA`=01, `ALUSrcB`=10, `ALUOp`=000.
- **LUI**: `ALUSrcA`=11, `ALUSrcB`=01, `ALUOp`=000.
- **AUIPC**: `ALUSrcA`=01, `ALUSrcB`=01, `ALUOp`=000.
- **TRAP**: all outputs 0 except `illegal_instr`.

Transitions:
- FETCH stays in FETCH while `mem_ready`=0, and goes to DECODE when it is 1.
- DECODE dispatches on `opcode`:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR
  - 0110111 → LUI
  - 0010111 → AUIPC
  - any other opcode → illegal handling (see Configuration)
- MEMADR → MEMREAD if `opcode[5]`=0, else MEMWRITE.
- MEMREAD holds until `mem_ready`, then goes to MEMWB.
- MEMWRITE holds until `mem_ready`, then goes to FETCH.
- EXECR, EXECI, JAL, LUI and AUIPC go to ALUWB. JALR goes to JALRLINK, which goes to ALUWB.
- ALUWB, MEMWB and BRANCH go to FETCH.

Other rules:
- `ImmSrc` is decoded combinationally from `opcode` in every state: I for 0000011, 0010011 and 1100111; S for 0100011; B for 1100011; J for 1101111; U for 0110111 and 0010111; 000 otherwise.
- `mem_req` stays high, with a stable address select, until the cycle `mem_ready` is sampled high.
- A `mem_ready` pulse outside FETCH, MEMREAD or MEMWRITE is ignored.

## Timing
- While `rst_n`=0: state is FETCH and every output is forced to 0. The first `mem_req` is asserted in the cycle after `rst_n` is released.
- Reset asserted mid-instruction aborts it immediately; no pending write completes.
- Cycles per instruction with zero-wait memory (`mem_ready` high on the first request cycle):
  - load: 5
  - store: 4
  - R-type and I-ALU: 4
  - branch: 3
  - JAL: 4
  - JALR: 5
  - LUI and AUIPC: 4
- Each memory wait cycle adds 1 to the count.
- `PCWrite` in FETCH and `IRWrite` coincide with the `mem_ready` cycle. PC+4 and the instruction commit on the same edge.

## Configuration
Macro `RISC_ILLEGAL_TRAP_EN`:
- **Defined**: an unknown opcode in DECODE goes to TRAP. `illegal_instr` is set and the FSM stays in TRAP until reset.
- **Undefined**: an unknown opcode in DECODE returns to FETCH and is executed as a NOP. `illegal_instr` is tied to 0 and TRAP is not synthesised.

## Test plan
- Reset released, `mem_ready`=1 from cycle 0, opcode 0110011 → states FETCH, DECODE, EXECR, ALUWB; `ALUOp`=010 in EXECR; `RegWrite`=1 only in cycle 4.
- Load (0000011) with `mem_ready` low for 3 cycles in MEMREAD → `mem_req` and `AdrSrc` stay 1 for 4 cycles; MEMWB is reached with `ResultSrc`=01; 8 cycles in total.
- Branch (1100011) run twice, once with `branch_taken`=1 and once with 0 → `PCWrite` is 1 in BRANCH only in the taken run; `ALUOp`=001 in both; `ImmSrc`=010.
- JALR (1100111) → `PCWrite`=1 with `ResultSrc`=10 in JALR; JALRLINK drives `ALUSrcA`=01 and `ALUSrcB`=10; `RegWrite`=1 in ALUWB.
- Opcode 1111111 with the macro defined → `illegal_instr`=1 from the cycle after DECODE and `mem_req` stays 0; after `rst_n` is pulsed low, `illegal_instr`=0 and fetch resumes. Without the macro → returns to FETCH with no writes.
- `rst_n` asserted during MEMWRITE while `mem_ready`=0 → `mem_req` and `MemWrite` drop to 0 asynchronously; FETCH is the first state after release.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller (master) and the datapath/memory (slave).
interface multicycle_controller_if;
   logic [6:0] opcode;
   logic       branch_taken;
   logic       mem_ready;
   logic       mem_req;
   logic       MemWrite;
   logic       AdrSrc;
   logic       IRWrite;
   logic       PCWrite;
   logic       RegWrite;
   logic [1:0] ResultSrc;
   logic [1:0] ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [2:0] ALUOp;
   logic [2:0] ImmSrc;
   logic       illegal_instr;

   modport master (
      input  opcode, branch_taken, mem_ready,
      output mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
             ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, illegal_instr
   );

   modport slave (
      output opcode, branch_taken, mem_ready,
      input  mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
             ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, illegal_instr
   );
endinterface

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle RV32I core with request/ready memory handshake.
// Define RISC_ILLEGAL_TRAP_EN to trap on unknown opcodes instead of treating them as NOPs.
module multicycle_controller (
   input logic                     clk,
   input logic                     rst_n,
   multicycle_controller_if.master bus
);

   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpReg    = 7'b0110011;
   localparam logic [6:0] OpImm    = 7'b0010011;
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpJal    = 7'b1101111;
   localparam logic [6:0] OpJalr   = 7'b1100111;
   localparam logic [6:0] OpLui    = 7'b0110111;
   localparam logic [6:0] OpAuipc  = 7'b0010111;

   typedef enum logic [3:0] {
      StFetch, StDecode, StMemAdr, StMemRead, StMemWrite, StMemWb, StExecR, StExecI,
      StAluWb, StBranch, StJal, StJalr, StJalrLink, StLui, StAuipc
`ifdef RISC_ILLEGAL_TRAP_EN
      , StTrap
`endif
   } state_e;

   state_e     state_q, state_d;
   logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, in_trap;
   logic [1:0] result_src, alu_src_a, alu_src_b;
   logic [2:0] alu_op, imm_src;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= StFetch;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      mem_req    = 1'b0;
      mem_write  = 1'b0;
      adr_src    = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      result_src = 2'b00;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      alu_op     = 3'b000;
      case (state_q)
         StFetch: begin
            mem_req    = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            ir_write   = bus.mem_ready;
            pc_write   = bus.mem_ready;
            if (bus.mem_ready) state_d = StDecode;
         end
         StDecode: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
            case (bus.opcode)
               OpLoad, OpStore: state_d = StMemAdr;
               OpReg:           state_d = StExecR;
               OpImm:           state_d = StExecI;
               OpBranch:        state_d = StBranch;
               OpJal:           state_d = StJal;
               OpJalr:          state_d = StJalr;
               OpLui:           state_d = StLui;
               OpAuipc:         state_d = StAuipc;
`ifdef RISC_ILLEGAL_TRAP_EN
               default:         state_d = StTrap;
`else
               default:         state_d = StFetch;
`endif
            endcase
         end
         StMemAdr: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            state_d   = bus.opcode[5] ? StMemWrite : StMemRead;
         end
         StMemRead: begin
            mem_req = 1'b1;
            adr_src = 1'b1;
            if (bus.mem_ready) state_d = StMemWb;
         end
         StMemWrite: begin
            mem_req   = 1'b1;
            adr_src   = 1'b1;
            mem_write = 1'b1;
            if (bus.mem_ready) state_d = StFetch;
         end
         StMemWb: begin
            result_src = 2'b01;
            reg_write  = 1'b1;
            state_d    = StFetch;
         end
         StExecR: begin
            alu_src_a = 2'b10;
            alu_op    = 3'b010;
            state_d   = StAluWb;
         end
         StExecI: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            alu_op    = 3'b010;
            state_d   = StAluWb;
         end
         StAluWb: begin
            reg_write = 1'b1;
            state_d   = StFetch;
         end
         StBranch: begin
            alu_src_a = 2'b10;
            alu_op    = 3'b001;
            pc_write  = bus.branch_taken;
            state_d   = StFetch;
         end
         StJal: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b10;
            pc_write  = 1'b1;
            state_d   = StAluWb;
         end
         StJalr: begin
            alu_src_a  = 2'b10;
            alu_src_b  = 2'b01;
            result_src = 2'b10;
            pc_write   = 1'b1;
            state_d    = StJalrLink;
         end
         StJalrLink: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b10;
            state_d   = StAluWb;
         end
         StLui: begin
            alu_src_a = 2'b11;
            alu_src_b = 2'b01;
            state_d   = StAluWb;
         end
         StAuipc: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
            state_d   = StAluWb;
         end
         default: state_d = state_q;
      endcase
   end

   always_comb begin
      imm_src = 3'b000;
      case (bus.opcode)
         OpLoad, OpImm, OpJalr: imm_src = 3'b000;
         OpStore:               imm_src = 3'b001;
         OpBranch:              imm_src = 3'b010;
         OpJal:                 imm_src = 3'b011;
         OpLui, OpAuipc:        imm_src = 3'b100;
         default:               imm_src = 3'b000;
      endcase
   end

`ifdef RISC_ILLEGAL_TRAP_EN
   assign in_trap = (state_q == StTrap);
`else
   assign in_trap = 1'b0;
`endif

   // Outputs are forced low while reset is held, independent of the clock.
   assign bus.mem_req       = rst_n & mem_req;
   assign bus.MemWrite      = rst_n & mem_write;
   assign bus.AdrSrc        = rst_n & adr_src;
   assign bus.IRWrite       = rst_n & ir_write;
   assign bus.PCWrite       = rst_n & pc_write;
   assign bus.RegWrite      = rst_n & reg_write;
   assign bus.ResultSrc     = rst_n ? result_src : 2'b00;
   assign bus.ALUSrcA       = rst_n ? alu_src_a : 2'b00;
   assign bus.ALUSrcB       = rst_n ? alu_src_b : 2'b00;
   assign bus.ALUOp         = rst_n ? alu_op : 3'b000;
   assign bus.ImmSrc        = (rst_n && !in_trap) ? imm_src : 3'b000;
   assign bus.illegal_instr = rst_n & in_trap;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomised bench for multicycle_controller: per-cycle output check against a phase-level model.
module tb_multicycle_controller;

   localparam int P_FETCH  = 0,  P_DECODE = 1,  P_MEMADR = 2,  P_MEMRD = 3,  P_MEMWR = 4;
   localparam int P_MEMWB  = 5,  P_EXECR  = 6,  P_EXECI  = 7,  P_ALUWB = 8,  P_BRANCH = 9;
   localparam int P_JAL    = 10, P_JALR   = 11, P_LINK   = 12, P_LUI   = 13, P_AUIPC = 14;
   localparam int P_TRAP   = 15, P_RESET  = 16;

   logic clk;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   multicycle_controller_if bus ();

   multicycle_controller dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [2:0] imm_of(logic [6:0] op);
      case (op)
         7'b0000011, 7'b0010011, 7'b1100111: return 3'b000;
         7'b0100011:                         return 3'b001;
         7'b1100011:                         return 3'b010;
         7'b1101111:                         return 3'b011;
         7'b0110111, 7'b0010111:             return 3'b100;
         default:                            return 3'b000;
      endcase
   endfunction

   // {mem_req,MemWrite,AdrSrc,IRWrite,PCWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUOp,ImmSrc,ill}
   function automatic logic [18:0] exp_out(int ph, bit mr, bit bt, logic [6:0] op);
      logic       mreq = 0, mw = 0, adr = 0, irw = 0, pcw = 0, rw = 0, ill = 0;
      logic [1:0] rs = 0, sa = 0, sb = 0;
      logic [2:0] aop = 0, imm;
      imm = imm_of(op);
      case (ph)
         P_FETCH:  begin mreq = 1; sb = 2; rs = 2; irw = mr; pcw = mr; end
         P_DECODE: begin sa = 1; sb = 1; end
         P_MEMADR: begin sa = 2; sb = 1; end
         P_MEMRD:  begin mreq = 1; adr = 1; end
         P_MEMWR:  begin mreq = 1; adr = 1; mw = 1; end
         P_MEMWB:  begin rs = 1; rw = 1; end
         P_EXECR:  begin sa = 2; aop = 2; end
         P_EXECI:  begin sa = 2; sb = 1; aop = 2; end
         P_ALUWB:  begin rw = 1; end
         P_BRANCH: begin sa = 2; aop = 1; pcw = bt; end
         P_JAL:    begin sa = 1; sb = 2; pcw = 1; end
         P_JALR:   begin sa = 2; sb = 1; rs = 2; pcw = 1; end
         P_LINK:   begin sa = 1; sb = 2; end
         P_LUI:    begin sa = 3; sb = 1; end
         P_AUIPC:  begin sa = 1; sb = 1; end
         P_TRAP:   begin imm = 0; ill = 1; end
         default:  begin imm = 0; end
      endcase
      return {mreq, mw, adr, irw, pcw, rw, rs, sa, sb, aop, imm, ill};
   endfunction

   function automatic logic [18:0] obs();
      return {bus.mem_req, bus.MemWrite, bus.AdrSrc, bus.IRWrite, bus.PCWrite, bus.RegWrite,
              bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.ImmSrc, bus.illegal_instr};
   endfunction

   task automatic chk(string tag, logic [18:0] o, logic [18:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, o, e);
      end
   endtask

   // One clock: called at a negedge, drives inputs, checks, returns at the next negedge.
   task automatic cyc(int ph, bit mr, bit bt, logic [6:0] op, string tag);
      bus.opcode       = op;
      bus.mem_ready    = mr;
      bus.branch_taken = bt;
      #1 chk(tag, obs(), exp_out(ph, mr, bt, op));
      @(negedge clk);
   endtask

   task automatic mem_phase(int ph, int dw, bit bt, logic [6:0] op, string tag);
      for (int k = 0; k < dw; k++) cyc(ph, 1'b0, bt, op, {tag, "_wait"});
      cyc(ph, 1'b1, bt, op, tag);
   endtask

   task automatic run_instr(logic [6:0] op, int fw, int dw, bit bt);
      mem_phase(P_FETCH, fw, bt, op, "fetch");
      cyc(P_DECODE, 1'($urandom), bt, op, "decode");
      case (op)
         7'b0000011: begin
            cyc(P_MEMADR, 1'($urandom), bt, op, "ld_memadr");
            mem_phase(P_MEMRD, dw, bt, op, "memread");
            cyc(P_MEMWB, 1'($urandom), bt, op, "memwb");
         end
         7'b0100011: begin
            cyc(P_MEMADR, 1'($urandom), bt, op, "st_memadr");
            mem_phase(P_MEMWR, dw, bt, op, "memwrite");
         end
         7'b0110011: begin
            cyc(P_EXECR, 1'($urandom), bt, op, "execr");
            cyc(P_ALUWB, 1'($urandom), bt, op, "aluwb_r");
         end
         7'b0010011: begin
            cyc(P_EXECI, 1'($urandom), bt, op, "execi");
            cyc(P_ALUWB, 1'($urandom), bt, op, "aluwb_i");
         end
         7'b1100011: cyc(P_BRANCH, 1'($urandom), bt, op, "branch");
         7'b1101111: begin
            cyc(P_JAL, 1'($urandom), bt, op, "jal");
            cyc(P_ALUWB, 1'($urandom), bt, op, "aluwb_jal");
         end
         7'b1100111: begin
            cyc(P_JALR, 1'($urandom), bt, op, "jalr");
            cyc(P_LINK, 1'($urandom), bt, op, "jalrlink");
            cyc(P_ALUWB, 1'($urandom), bt, op, "aluwb_jalr");
         end
         7'b0110111: begin
            cyc(P_LUI, 1'($urandom), bt, op, "lui");
            cyc(P_ALUWB, 1'($urandom), bt, op, "aluwb_lui");
         end
         7'b0010111: begin
            cyc(P_AUIPC, 1'($urandom), bt, op, "auipc");
            cyc(P_ALUWB, 1'($urandom), bt, op, "aluwb_auipc");
         end
         default: ;
      endcase
   endtask

   logic [6:0] legal_ops [9] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                                 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
   logic [6:0] bad_ops [4]   = '{7'b1111111, 7'b0000000, 7'b0001111, 7'b1110011};

   initial begin
      logic [6:0] op;
      rst_n            = 1'b0;
      bus.opcode       = 7'b0110011;
      bus.mem_ready    = 1'b1;
      bus.branch_taken = 1'b1;
      #1 chk("reset_outputs", obs(), exp_out(P_RESET, 1'b1, 1'b1, 7'b0110011));
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed cases from the block's test plan.
      run_instr(7'b0110011, 0, 0, 1'b0);
      run_instr(7'b0000011, 0, 3, 1'b0);
      run_instr(7'b1100011, 0, 0, 1'b1);
      run_instr(7'b1100011, 0, 0, 1'b0);
      run_instr(7'b1100111, 0, 0, 1'b0);

      for (int n = 0; n < 120; n++) begin
`ifdef RISC_ILLEGAL_TRAP_EN
         op = legal_ops[$urandom_range(0, 8)];
`else
         if ($urandom_range(0, 9) == 0) op = bad_ops[$urandom_range(0, 3)];
         else                           op = legal_ops[$urandom_range(0, 8)];
`endif
         run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom));
      end

      // Reset in the middle of a stalled store.
      cyc(P_FETCH, 1'b1, 1'b0, 7'b0100011, "st_fetch");
      cyc(P_DECODE, 1'b0, 1'b0, 7'b0100011, "st_decode");
      cyc(P_MEMADR, 1'b0, 1'b0, 7'b0100011, "st_memadr2");
      bus.mem_ready = 1'b0;
      #1 chk("memwrite_stall", obs(), exp_out(P_MEMWR, 1'b0, 1'b0, 7'b0100011));
      #1 rst_n = 1'b0;
      #1 chk("async_reset", obs(), exp_out(P_RESET, 1'b0, 1'b0, 7'b0100011));
      @(negedge clk);
      bus.mem_ready = 1'b1;
      #1 chk("reset_hold", obs(), exp_out(P_RESET, 1'b1, 1'b0, 7'b0100011));
      @(negedge clk);
      rst_n = 1'b1;
      run_instr(7'b0110011, 1, 0, 1'b0);

      // Unknown opcode.
`ifdef RISC_ILLEGAL_TRAP_EN
      cyc(P_FETCH, 1'b1, 1'b0, 7'b1111111, "ill_fetch");
      cyc(P_DECODE, 1'b1, 1'b0, 7'b1111111, "ill_decode");
      for (int k = 0; k < 3; k++) cyc(P_TRAP, 1'b1, 1'b0, 7'b1111111, "trap");
      rst_n = 1'b0;
      #1 chk("trap_reset", obs(), exp_out(P_RESET, 1'b1, 1'b0, 7'b1111111));
      @(negedge clk);
      rst_n = 1'b1;
      run_instr(7'b0010011, 0, 0, 1'b0);
`else
      run_instr(7'b1111111, 0, 0, 1'b0);
      run_instr(7'b0010011, 0, 0, 1'b0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
